// File: rtl/tlul_sram_device_adapter.sv
// TL-UL device adapter onto a simple req/gnt/rvalid SRAM port, with in-order responses.
// Optional request checking is enabled by defining TLUL_SRAM_ADAPTER_ERRCHK_EN.

package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// Linear parity-based response/data integrity; all-zero fields give an all-zero code.
module tlul_rsp_intg_gen (
  input  logic [2:0]  opcode,
  input  logic [1:0]  size,
  input  logic [7:0]  source,
  input  logic        error,
  input  logic [31:0] data,
  output logic [6:0]  rsp_intg,
  output logic [6:0]  data_intg
);
  function automatic logic [31:0] sel_mask(input int bit_idx);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) begin
      m[k] = (bit_idx == 6) || ((((k + 1) >> bit_idx) & 1) != 0);
    end
    return m;
  endfunction

  logic [31:0] rsp_vec;
  assign rsp_vec = {18'b0, opcode, size, source, error};

  for (genvar gi = 0; gi < 7; gi++) begin : g_intg
    localparam logic [31:0] Sel = sel_mask(gi);
    assign data_intg[gi] = ^(data & Sel);
    assign rsp_intg[gi]  = ^(rsp_vec & Sel);
  end
endmodule

module tlul_sram_device_adapter #(
  parameter int Outstanding = 2,
  parameter int MemAddrW    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  tlul_pkg::tl_h2d_t   tl_i,
  output tlul_pkg::tl_d2h_t   tl_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic                mem_we_o,
  output logic [MemAddrW-1:0] mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  output logic [3:0]          mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  input  logic                mem_err_i
);
  import tlul_pkg::*;

  localparam int IdxW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CntW = $clog2(Outstanding + 1);
  localparam logic [CntW-1:0] Depth = CntW'(Outstanding);

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    if (p == IdxW'(Outstanding - 1)) return '0;
    return p + IdxW'(1);
  endfunction

  // Request-info FIFO
  logic [7:0]      info_source_mem [Outstanding];
  logic [1:0]      info_size_mem   [Outstanding];
  logic            info_data_mem   [Outstanding];
  logic            info_lerr_mem   [Outstanding];
  logic [CntW-1:0] info_cnt_reg;
  logic [IdxW-1:0] info_wr_reg, info_rd_reg;

  // Response FIFO
  logic [31:0]     rsp_data_mem [Outstanding];
  logic            rsp_err_mem  [Outstanding];
  logic [CntW-1:0] rsp_cnt_reg;
  logic [IdxW-1:0] rsp_wr_reg, rsp_rd_reg;

  logic local_err;
  logic info_empty, info_full, rsp_empty, rsp_full;
  logic head_lerr, head_data, rsp_ok;
  logic d_valid, d_pop, rsp_pop, info_space, a_ready, a_accept;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic [6:0]  rsp_intg, data_intg;
  logic        unused_tl;

  assign unused_tl = ^tl_i;

`ifdef TLUL_SRAM_ADAPTER_ERRCHK_EN
  logic [3:0] lane_mask;
  logic       op_ok, size_ok, align_ok, mask_ok, full_ok;

  always_comb begin
    op_ok   = (tl_i.a_opcode == Get) || (tl_i.a_opcode == PutFullData) ||
              (tl_i.a_opcode == PutPartialData);
    size_ok = (tl_i.a_size <= 2'd2);
    case (tl_i.a_size)
      2'd0: begin
        lane_mask = 4'b0001 << tl_i.a_address[1:0];
        align_ok  = 1'b1;
      end
      2'd1: begin
        lane_mask = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
        align_ok  = ~tl_i.a_address[0];
      end
      default: begin
        lane_mask = 4'b1111;
        align_ok  = (tl_i.a_address[1:0] == 2'b00);
      end
    endcase
    mask_ok   = ((tl_i.a_mask & ~lane_mask) == 4'b0000);
    full_ok   = (tl_i.a_opcode != PutFullData) || (tl_i.a_mask == lane_mask);
    local_err = ~(op_ok & size_ok & align_ok & mask_ok & full_ok);
  end
`else
  assign local_err = 1'b0;
`endif

  assign info_empty = (info_cnt_reg == '0);
  assign info_full  = (info_cnt_reg == Depth);
  assign rsp_empty  = (rsp_cnt_reg == '0);
  assign rsp_full   = (rsp_cnt_reg == Depth);
  assign head_lerr  = info_lerr_mem[info_rd_reg];
  assign head_data  = info_data_mem[info_rd_reg];

  // d_valid is built only from FIFO state, never from mem_rvalid_i directly.
  assign d_valid    = ~info_empty & (head_lerr | ~rsp_empty);
  assign d_pop      = d_valid & tl_i.d_ready;
  assign rsp_pop    = d_pop & ~head_lerr;
  // A pop this cycle frees a slot, so a full FIFO can still accept.
  assign info_space = ~rst_i & (~info_full | d_pop);
  assign mem_req_o  = tl_i.a_valid & ~local_err & info_space;
  assign a_ready    = info_space & (mem_gnt_i | local_err);
  assign a_accept   = tl_i.a_valid & a_ready;

  assign mem_we_o    = mem_req_o & (tl_i.a_opcode != Get);
  assign mem_addr_o  = mem_req_o ? tl_i.a_address[MemAddrW+1:2] : '0;
  assign mem_wdata_o = mem_req_o ? tl_i.a_data : '0;
  assign mem_be_o    = mem_req_o ? tl_i.a_mask : '0;

  always_ff @(posedge clk_i) begin
    if (a_accept) begin
      info_source_mem[info_wr_reg] <= tl_i.a_source;
      info_size_mem[info_wr_reg]   <= tl_i.a_size;
      info_data_mem[info_wr_reg]   <= (tl_i.a_opcode == Get);
      info_lerr_mem[info_wr_reg]   <= local_err;
    end
    if (mem_rvalid_i) begin
      rsp_data_mem[rsp_wr_reg] <= mem_rdata_i;
      rsp_err_mem[rsp_wr_reg]  <= mem_err_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      info_cnt_reg <= '0;
      info_wr_reg  <= '0;
      info_rd_reg  <= '0;
      rsp_cnt_reg  <= '0;
      rsp_wr_reg   <= '0;
      rsp_rd_reg   <= '0;
    end else begin
      if (a_accept) info_wr_reg <= ptr_inc(info_wr_reg);
      if (d_pop)    info_rd_reg <= ptr_inc(info_rd_reg);
      case ({a_accept, d_pop})
        2'b10:   info_cnt_reg <= info_cnt_reg + CntW'(1);
        2'b01:   info_cnt_reg <= info_cnt_reg - CntW'(1);
        default: info_cnt_reg <= info_cnt_reg;
      endcase

      if (mem_rvalid_i) rsp_wr_reg <= ptr_inc(rsp_wr_reg);
      if (rsp_pop)      rsp_rd_reg <= ptr_inc(rsp_rd_reg);
      case ({mem_rvalid_i, rsp_pop})
        2'b10:   rsp_cnt_reg <= rsp_cnt_reg + CntW'(1);
        2'b01:   rsp_cnt_reg <= rsp_cnt_reg - CntW'(1);
        default: rsp_cnt_reg <= rsp_cnt_reg;
      endcase
    end
  end

  // D fields are gated to zero while there is nothing to report.
  always_comb begin
    rsp_ok   = ~info_empty & ~head_lerr & ~rsp_empty;
    d_opcode = info_empty ? 3'h0 : (head_data ? AccessAckData : AccessAck);
    d_size   = info_empty ? 2'h0 : info_size_mem[info_rd_reg];
    d_source = info_empty ? 8'h0 : info_source_mem[info_rd_reg];
    d_data   = (rsp_ok & head_data) ? rsp_data_mem[rsp_rd_reg] : 32'h0;
    d_error  = ~info_empty & (head_lerr | (rsp_ok & rsp_err_mem[rsp_rd_reg]));
  end

  tlul_rsp_intg_gen u_intg (
    .opcode   (d_opcode),
    .size     (d_size),
    .source   (d_source),
    .error    (d_error),
    .data     (d_data),
    .rsp_intg (rsp_intg),
    .data_intg(data_intg)
  );

  always_comb begin
    tl_o                  = '0;
    tl_o.a_ready          = a_ready;
    tl_o.d_valid          = d_valid;
    tl_o.d_opcode         = d_opcode;
    tl_o.d_size           = d_size;
    tl_o.d_source         = d_source;
    tl_o.d_data           = d_data;
    tl_o.d_error          = d_error;
    tl_o.d_user.rsp_intg  = rsp_intg;
    tl_o.d_user.data_intg = data_intg;
  end

  rsp_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_rvalid_i && rsp_full && !rsp_pop))
    else $error("mem_rvalid_i arrived with response FIFO full");
endmodule

// File: tb/tb_tlul_sram_device_adapter.sv
// Directed bench for tlul_sram_device_adapter: vector table plus stall, back-pressure,
// local-error and reset sequences against a 1-cycle-latency memory responder.
module tb_tlul_sram_device_adapter;
  import tlul_pkg::*;

  logic              clk_i;
  logic              rst_i;
  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic              mem_req_o, mem_gnt_i, mem_we_o;
  logic [15:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              mem_err_i;
  logic              err_next;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tlul_sram_device_adapter #(.Outstanding(2), .MemAddrW(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_err_i   (mem_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory responder: one response per grant, one cycle later; cleared by rst_i.
  logic [31:0] mem_array [256];
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= '0;
      mem_err_i    <= 1'b0;
      for (int i = 0; i < 256; i++) mem_array[i] <= '0;
    end else begin
      mem_rvalid_i <= mem_req_o && mem_gnt_i;
      mem_err_i    <= mem_req_o && mem_gnt_i && err_next;
      mem_rdata_i  <= '0;
      if (mem_req_o && mem_gnt_i) begin
        if (!mem_we_o) mem_rdata_i <= mem_array[mem_addr_o[7:0]];
        else
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem_array[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
    logic        inj;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [3:0]  exp_be;
    logic [2:0]  exp_dop;
    logic [31:0] exp_ddata;
    logic        exp_derr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    total_cnt++;
    $display("FAIL %s: no event within 20 cycles, expected one", name);
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_size    = sz;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tl_o.a_ready && n < 20) begin @(negedge clk_i); #1; n++; end
    if (!tl_o.a_ready) tmo("a_ready_wait");
  endtask

  task automatic wait_d();
    int n = 0;
    while (!tl_o.d_valid && n < 20) begin @(negedge clk_i); #1; n++; end
    if (!tl_o.d_valid) tmo("d_valid_wait");
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk_i);
    drive_a(v.op, v.size, v.addr, v.mask, v.data, v.src);
    err_next = v.inj;
    #1;
    wait_ready();
    chk("vec_mem_req", 32'(mem_req_o), 1);
    chk("vec_mem_we", 32'(mem_we_o), 32'(v.exp_we));
    chk("vec_mem_addr", 32'(mem_addr_o), 32'(v.exp_addr));
    chk("vec_mem_be", 32'(mem_be_o), 32'(v.exp_be));
    if (v.exp_we) chk("vec_mem_wdata", mem_wdata_o, v.data);
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    err_next = 1'b0;
    #1;
    wait_d();
    chk("vec_d_opcode", 32'(tl_o.d_opcode), 32'(v.exp_dop));
    chk("vec_d_data", tl_o.d_data, v.exp_ddata);
    chk("vec_d_error", 32'(tl_o.d_error), 32'(v.exp_derr));
    chk("vec_d_source", 32'(tl_o.d_source), 32'(v.src));
    chk("vec_d_size", 32'(tl_o.d_size), 32'(v.size));
    $display("vec %0d op=%0d addr=0x%08h src=0x%02h -> d_data=0x%08h d_error=%0d",
             idx, v.op, v.addr, v.src, tl_o.d_data, tl_o.d_error);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, size, addr, mask, data, src, inj | we, maddr, be, dop, ddata, derr
    vq.push_back('{PutFullData,    2'd2, 32'h10,        4'hF, 32'hDEADBEEF, 8'h01, 1'b0, 1'b1, 16'h0004, 4'hF, AccessAck,     32'h0,        1'b0});
    vq.push_back('{Get,            2'd2, 32'h10,        4'hF, 32'h0,        8'h03, 1'b0, 1'b0, 16'h0004, 4'hF, AccessAckData, 32'hDEADBEEF, 1'b0});
    vq.push_back('{PutPartialData, 2'd1, 32'h20,        4'h3, 32'h12345678, 8'h02, 1'b0, 1'b1, 16'h0008, 4'h3, AccessAck,     32'h0,        1'b0});
    vq.push_back('{Get,            2'd2, 32'h20,        4'hF, 32'h0,        8'h05, 1'b0, 1'b0, 16'h0008, 4'hF, AccessAckData, 32'h00005678, 1'b0});
    vq.push_back('{PutFullData,    2'd2, 32'h3FC,       4'hF, 32'hA5A50F0F, 8'h07, 1'b0, 1'b1, 16'h00FF, 4'hF, AccessAck,     32'h0,        1'b0});
    vq.push_back('{Get,            2'd2, 32'h3FC,       4'hF, 32'h0,        8'h2A, 1'b0, 1'b0, 16'h00FF, 4'hF, AccessAckData, 32'hA5A50F0F, 1'b0});
    vq.push_back('{PutFullData,    2'd2, 32'h3FC,       4'hF, 32'h11111111, 8'h09, 1'b1, 1'b1, 16'h00FF, 4'hF, AccessAck,     32'h0,        1'b1});
    vq.push_back('{Get,            2'd2, 32'h10,        4'hF, 32'h0,        8'h80, 1'b1, 1'b0, 16'h0004, 4'hF, AccessAckData, 32'hDEADBEEF, 1'b1});
    vq.push_back('{Get,            2'd2, 32'hFFFC0004,  4'hF, 32'h0,        8'hFF, 1'b0, 1'b0, 16'h0001, 4'hF, AccessAckData, 32'h0,        1'b0});
    vq.push_back('{PutPartialData, 2'd0, 32'h21,        4'h2, 32'h0000AB00, 8'h04, 1'b0, 1'b1, 16'h0008, 4'h2, AccessAck,     32'h0,        1'b0});
    vq.push_back('{Get,            2'd0, 32'h21,        4'h2, 32'h0,        8'h06, 1'b0, 1'b0, 16'h0008, 4'h2, AccessAckData, 32'h0000AB78, 1'b0});

    // Reset state with a request already presented
    rst_i = 1'b1;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    mem_gnt_i = 1'b1;
    err_next = 1'b0;
    drive_a(Get, 2'd2, 32'h40, 4'hF, 32'h0, 8'h11);
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_a_ready", 32'(tl_o.a_ready), 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_d_valid", 32'(tl_o.d_valid), 0);
    chk("rst_mem_addr", 32'(mem_addr_o), 0);
    chk("rst_mem_we", 32'(mem_we_o), 0);
    chk("rst_d_data", tl_o.d_data, 0);
    $display("reset: a_ready=%0d mem_req=%0d d_valid=%0d", tl_o.a_ready, mem_req_o, tl_o.d_valid);

    // First accept in the first cycle after release
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("first_a_ready", 32'(tl_o.a_ready), 1);
    chk("first_mem_req", 32'(mem_req_o), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    #1;
    wait_d();
    chk("first_d_source", 32'(tl_o.d_source), 32'h11);
    chk("first_d_data", tl_o.d_data, 0);
    $display("first get: d_source=0x%02h d_data=0x%08h", tl_o.d_source, tl_o.d_data);

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Grant stall: request held, a_ready low until granted
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    drive_a(Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'h33);
    #1;
    chk("stall_a_ready", 32'(tl_o.a_ready), 0);
    chk("stall_mem_req", 32'(mem_req_o), 1);
    @(negedge clk_i);
    mem_gnt_i = 1'b1;
    #1;
    chk("stall_gnt_a_ready", 32'(tl_o.a_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    #1;
    wait_d();
    chk("stall_d_data", tl_o.d_data, 32'hDEADBEEF);
    $display("gnt stall: d_data=0x%08h", tl_o.d_data);

    // Three back-to-back Gets with D stalled: third waits for the first pop
    @(negedge clk_i);
    tl_i.d_ready = 1'b0;
    drive_a(Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'h41);
    #1;
    chk("b2b_1_a_ready", 32'(tl_o.a_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    drive_a(Get, 2'd2, 32'h20, 4'hF, 32'h0, 8'h42);
    #1;
    chk("b2b_2_a_ready", 32'(tl_o.a_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    drive_a(Get, 2'd2, 32'h3FC, 4'hF, 32'h0, 8'h43);
    #1;
    chk("b2b_3_a_ready_full", 32'(tl_o.a_ready), 0);
    chk("b2b_3_mem_req_full", 32'(mem_req_o), 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      #1;
      chk("b2b_held_a_ready", 32'(tl_o.a_ready), 0);
      chk("b2b_held_d_valid", 32'(tl_o.d_valid), 1);
      chk("b2b_held_d_source", 32'(tl_o.d_source), 32'h41);
      chk("b2b_held_d_data", tl_o.d_data, 32'hDEADBEEF);
    end
    tl_i.d_ready = 1'b1;
    #1;
    chk("b2b_pop_accept_a_ready", 32'(tl_o.a_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    #1;
    wait_d();
    chk("b2b_2nd_d_source", 32'(tl_o.d_source), 32'h42);
    chk("b2b_2nd_d_data", tl_o.d_data, 32'h0000AB78);
    @(negedge clk_i);
    #1;
    wait_d();
    chk("b2b_3rd_d_source", 32'(tl_o.d_source), 32'h43);
    chk("b2b_3rd_d_data", tl_o.d_data, 32'h11111111);
    $display("back-to-back: third d_source=0x%02h d_data=0x%08h", tl_o.d_source, tl_o.d_data);

    // Misaligned word Get behind a pending Get
    @(negedge clk_i);
    tl_i.d_ready = 1'b0;
    drive_a(Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'h51);
    #1;
    @(posedge clk_i);
    @(negedge clk_i);
    drive_a(Get, 2'd2, 32'h2, 4'hF, 32'h0, 8'h52);
    #1;
    chk("lerr_a_ready", 32'(tl_o.a_ready), 1);
`ifdef TLUL_SRAM_ADAPTER_ERRCHK_EN
    chk("lerr_mem_req", 32'(mem_req_o), 0);
`else
    chk("lerr_mem_req", 32'(mem_req_o), 1);
    chk("lerr_mem_addr", 32'(mem_addr_o), 0);
`endif
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    #1;
    wait_d();
    chk("lerr_1st_d_source", 32'(tl_o.d_source), 32'h51);
    chk("lerr_1st_d_error", 32'(tl_o.d_error), 0);
    chk("lerr_1st_d_data", tl_o.d_data, 32'hDEADBEEF);
    @(negedge clk_i);
    #1;
    wait_d();
    chk("lerr_2nd_d_source", 32'(tl_o.d_source), 32'h52);
`ifdef TLUL_SRAM_ADAPTER_ERRCHK_EN
    chk("lerr_2nd_d_error", 32'(tl_o.d_error), 1);
`else
    chk("lerr_2nd_d_error", 32'(tl_o.d_error), 0);
`endif
    chk("lerr_2nd_d_data", tl_o.d_data, 0);
    $display("misaligned get: d_source=0x%02h d_error=%0d", tl_o.d_source, tl_o.d_error);

    // Reset with two pending requests
    @(negedge clk_i);
    tl_i.d_ready = 1'b0;
    drive_a(Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'h61);
    #1;
    @(posedge clk_i);
    @(negedge clk_i);
    drive_a(Get, 2'd2, 32'h20, 4'hF, 32'h0, 8'h62);
    #1;
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    #1;
    chk("midrst_pending_d_valid", 32'(tl_o.d_valid), 1);
    rst_i = 1'b1;
    #1;
    chk("midrst_d_valid", 32'(tl_o.d_valid), 0);
    chk("midrst_a_ready", 32'(tl_o.a_ready), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tl_i.d_ready = 1'b1;
    drive_a(Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'h63);
    #1;
    chk("postrst_a_ready", 32'(tl_o.a_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    #1;
    wait_d();
    chk("postrst_d_source", 32'(tl_o.d_source), 32'h63);
    chk("postrst_d_data", tl_o.d_data, 0);
    chk("postrst_d_error", 32'(tl_o.d_error), 0);
    @(negedge clk_i);
    #1;
    chk("postrst_drained", 32'(tl_o.d_valid), 0);
    $display("reset mid-op: post-reset d_source=0x63 completed, d_valid now %0d", tl_o.d_valid);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
